// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage_pkg
// Brief    : Shared result-select encodings and MEM-stage FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage_if
// Brief    : Data-memory request/acknowledge bus between MEM stage and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage_regpipe.sv
`default_nettype none
// ============================================================================
// Module   : regPipe
// Brief    : Pipeline register with synchronous clear (bubble) and enable.
// Revision : 1.0 - initial release
// ============================================================================
module regPipe #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over enable so a bubble is inserted even on a loading edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Brief    : MEM->WB stage with stalling data-memory handshake; optional
//            access timeout enabled by macro DMEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic             MemWriteM,
    input  logic             LUIInstrM,
    input  logic [4:0]       RdM,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  WriteDataM,
    input  logic [XLEN-1:0]  ExtImmM,
    input  logic [XLEN-1:0]  PCPlus4M,
    mem_wb_stage_if.master   dmem,
    output logic             StallM,
    output logic             RegWriteW,
    output logic [4:0]       RdW,
    output logic [XLEN-1:0]  ResultW,
    output logic             mem_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_wb_stage: TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_e      state_q, state_d;
    logic            w_memop;
    logic            w_req;
    logic            w_stall;
    logic            w_bubble;
    logic            w_ack;
    logic [XLEN-1:0] w_result;

    assign w_memop = MemWriteM | (ResultSrcM == RES_MEM);
    assign w_ack   = w_req & dmem.dmem_ack;

`ifdef DMEM_TIMEOUT_EN
    localparam int               C_CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LIMIT = C_CNT_W'(TIMEOUT_CYCLES);

    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic [C_CNT_W-1:0] w_cnt_inc;
    logic               mem_err_q;

    // The first stalled cycle is spent in IDLE, so it is counted too.
    assign w_cnt_inc = cnt_q + C_CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == ABORT) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        w_req    = 1'b0;
        w_stall  = 1'b0;
        w_bubble = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE, WAIT: begin
                if (w_memop || (state_q == WAIT)) begin
                    w_req = 1'b1;
                    if (dmem.dmem_ack) begin
                        state_d = IDLE;
`ifdef DMEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                        state_d  = WAIT;
`ifdef DMEM_TIMEOUT_EN
                        cnt_d    = w_cnt_inc;
                        if (w_cnt_inc == C_CNT_LIMIT) begin
                            state_d = ABORT;
                        end
`endif
                    end
                end
            end
`ifdef DMEM_TIMEOUT_EN
            ABORT: begin
                w_bubble = 1'b1;
                state_d  = IDLE;
                cnt_d    = '0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Gate with reset so an in-flight request vanishes without waiting for clk.
    assign dmem.dmem_req   = w_req & rst;
    assign StallM          = w_stall & rst;
    assign dmem.dmem_we    = MemWriteM;
    assign dmem.dmem_addr  = ALUResultM;
    assign dmem.dmem_wdata = WriteDataM;

    always_comb begin
        w_result = ALUResultM;
        if (LUIInstrM) begin
            w_result = ExtImmM;
        end else begin
            case (ResultSrcM)
                RES_ALU: w_result = ALUResultM;
                RES_MEM: w_result = dmem.dmem_rdata;
                RES_PC4: w_result = PCPlus4M;
                RES_IMM: w_result = ExtImmM;
                default: w_result = ALUResultM;
            endcase
        end
    end

    logic unused_ack;
    assign unused_ack = w_ack;

    regPipe #(
        .WIDTH (1 + 5 + XLEN)
    ) u_wb_reg (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_bubble),
        .enable (1'b1),
        .d      ({RegWriteM & ~MemWriteM, RdM, w_result}),
        .q      ({RegWriteW, RdW, ResultW})
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Brief    : Self-checking bench for mem_wb_stage (vector table + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int XLEN = 32;
    localparam int TMO  = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            RegWriteM, MemWriteM, LUIInstrM;
    logic [1:0]      ResultSrcM;
    logic [4:0]      RdM;
    logic [XLEN-1:0] ALUResultM, WriteDataM, ExtImmM, PCPlus4M;
    logic            StallM, RegWriteW, mem_err;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;

    mem_wb_stage_if #(.XLEN(XLEN)) dmem_bus ();

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .LUIInstrM  (LUIInstrM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ExtImmM    (ExtImmM),
        .PCPlus4M   (PCPlus4M),
        .dmem       (dmem_bus),
        .StallM     (StallM),
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .ResultW    (ResultW),
        .mem_err    (mem_err)
    );

    typedef struct {
        logic        rw;
        logic [1:0]  src;
        logic        mw;
        logic        lui;
        logic [4:0]  rd;
        logic [31:0] alu, wd, imm, pc4, rdata;
        int          delay;
        logic        exp_rw;
        logic [4:0]  exp_rd;
        logic [31:0] exp_res;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic [1:0] src, input logic mw,
                                input logic lui, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] wd,
                                input logic [31:0] imm, input logic [31:0] pc4,
                                input logic [31:0] rdata, input int delay,
                                input logic erw, input logic [4:0] erd,
                                input logic [31:0] eres);
        vec_t v;
        v.rw = rw; v.src = src; v.mw = mw; v.lui = lui; v.rd = rd;
        v.alu = alu; v.wd = wd; v.imm = imm; v.pc4 = pc4; v.rdata = rdata;
        v.delay = delay; v.exp_rw = erw; v.exp_rd = erd; v.exp_res = eres;
        return v;
    endfunction

    // Architectural view: what the register file should receive for one instruction.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_rw = v.rw && !v.mw;
        r.exp_rd = v.rd;
        if (v.lui)            r.exp_res = v.imm;
        else if (v.src == 0)  r.exp_res = v.alu;
        else if (v.src == 1)  r.exp_res = v.rdata;
        else if (v.src == 2)  r.exp_res = v.pc4;
        else                  r.exp_res = v.imm;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        RegWriteM = v.rw; ResultSrcM = v.src; MemWriteM = v.mw; LUIInstrM = v.lui;
        RdM = v.rd; ALUResultM = v.alu; WriteDataM = v.wd; ExtImmM = v.imm;
        PCPlus4M = v.pc4;
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // following the cycle in which the instruction retires into W.
    task automatic apply(input vec_t v);
        bit memop = v.mw || (v.src == 2'b01);
        drive(v);
        if (memop) begin
            for (int k = 0; k < v.delay; k++) begin
                dmem_bus.dmem_ack   = 1'b0;
                dmem_bus.dmem_rdata = $urandom;
                #1;
                check("stall_req", dmem_bus.dmem_req, 1'b1);
                check("stall_StallM", StallM, 1'b1);
                check("stall_addr", dmem_bus.dmem_addr, v.alu);
                check("stall_we", dmem_bus.dmem_we, v.mw);
                if (v.mw) check("stall_wdata", dmem_bus.dmem_wdata, v.wd);
                @(negedge clk);
                check("bubble_RegWriteW", RegWriteW, 1'b0);
            end
            dmem_bus.dmem_ack   = 1'b1;
            dmem_bus.dmem_rdata = v.rdata;
            #1;
            check("ack_req", dmem_bus.dmem_req, 1'b1);
            check("ack_StallM", StallM, 1'b0);
            check("ack_addr", dmem_bus.dmem_addr, v.alu);
            check("ack_we", dmem_bus.dmem_we, v.mw);
            if (v.mw) check("ack_wdata", dmem_bus.dmem_wdata, v.wd);
        end else begin
            dmem_bus.dmem_ack   = 1'($urandom_range(0, 1));
            dmem_bus.dmem_rdata = $urandom;
            #1;
            check("nomem_req", dmem_bus.dmem_req, 1'b0);
            check("nomem_StallM", StallM, 1'b0);
        end
        @(negedge clk);
        check("RegWriteW", RegWriteW, v.exp_rw);
        check("RdW", RdW, v.exp_rd);
        check("ResultW", ResultW, v.exp_res);
        dmem_bus.dmem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   cnt;

        vecs.push_back(mk(1, 2'd0, 0, 0, 5'd5,  32'h10, 0, 32'h999, 32'h4, 0, 0, 1, 5'd5, 32'h10));
        vecs.push_back(mk(1, 2'd1, 0, 0, 5'd7,  32'h40, 0, 0, 0, 32'hDEADBEEF, 3, 1, 5'd7, 32'hDEADBEEF));
        vecs.push_back(mk(1, 2'd0, 1, 0, 5'd3,  32'h80, 32'hCAFEF00D, 0, 0, 0, 0, 0, 5'd3, 32'h80));
        vecs.push_back(mk(1, 2'd2, 0, 1, 5'd9,  32'h5, 0, 32'h12345000, 32'h200, 0, 0, 1, 5'd9, 32'h12345000));
        vecs.push_back(mk(1, 2'd0, 0, 1, 5'd10, 32'h5, 0, 32'h12345000, 32'h200, 0, 0, 1, 5'd10, 32'h12345000));
        vecs.push_back(mk(1, 2'd2, 0, 0, 5'd1,  32'h5, 0, 32'h77, 32'h104, 0, 0, 1, 5'd1, 32'h104));
        vecs.push_back(mk(1, 2'd3, 0, 0, 5'd31, 32'h5, 0, 32'hABC00, 32'h0, 0, 0, 1, 5'd31, 32'hABC00));
        vecs.push_back(mk(1, 2'd0, 1, 0, 5'd4,  32'h84, 32'h11223344, 0, 0, 0, 2, 0, 5'd4, 32'h84));
        vecs.push_back(mk(0, 2'd0, 0, 0, 5'd6,  32'h55, 0, 0, 0, 0, 0, 0, 5'd6, 32'h55));
        vecs.push_back(mk(1, 2'd1, 0, 0, 5'd8,  32'h48, 0, 0, 0, 32'h0BADF00D, 0, 1, 5'd8, 32'h0BADF00D));
        vecs.push_back(mk(0, 2'd1, 0, 0, 5'd2,  32'h4C, 0, 0, 0, 32'h13579BDF, 1, 0, 5'd2, 32'h13579BDF));

        // Reset with a pending load on the inputs: the bus must stay quiet.
        rst = 1'b0;
        drive(mk(1, 2'd1, 0, 0, 5'd7, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0));
        dmem_bus.dmem_ack = 1'b0;
        dmem_bus.dmem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_RegWriteW", RegWriteW, 1'b0);
        check("rst_RdW", RdW, 5'd0);
        check("rst_ResultW", ResultW, 32'h0);
        check("rst_mem_err", mem_err, 1'b0);
        check("rst_req", dmem_bus.dmem_req, 1'b0);
        check("rst_StallM", StallM, 1'b0);
        drive(mk(0, 2'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) apply(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            v.rw    = 1'($urandom_range(0, 1));
            v.mw    = ($urandom_range(0, 3) == 0);
            v.lui   = ($urandom_range(0, 7) == 0);
            v.src   = 2'($urandom_range(0, 3));
            if (v.lui && v.src == 2'd1) v.src = 2'd3;
            v.rd    = 5'($urandom);
            v.alu   = $urandom; v.wd = $urandom; v.imm = $urandom;
            v.pc4   = $urandom; v.rdata = $urandom;
            v.delay = $urandom_range(0, 4);
            apply(model(v));
        end

        // Asynchronous reset mid-cycle clears a loaded W register.
        apply(model(mk(1, 2'd0, 0, 0, 5'd12, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0)));
        #2 rst = 1'b0;
        #1;
        check("async_RegWriteW", RegWriteW, 1'b0);
        check("async_RdW", RdW, 5'd0);
        check("async_ResultW", ResultW, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Reset while waiting on memory drops the request in the same cycle.
        drive(mk(1, 2'd1, 0, 0, 5'd14, 32'h90, 0, 0, 0, 0, 0, 0, 0, 0));
        dmem_bus.dmem_ack = 1'b0;
        #1 check("wr_first_StallM", StallM, 1'b1);
        @(negedge clk);
        #1 check("wr_wait_StallM", StallM, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("wr_rst_req", dmem_bus.dmem_req, 1'b0);
        check("wr_rst_StallM", StallM, 1'b0);
        check("wr_rst_ResultW", ResultW, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = 32'hA5A5_0F0F;
        #1;
        check("wr_post_StallM", StallM, 1'b0);
        check("wr_post_req", dmem_bus.dmem_req, 1'b1);
        @(negedge clk);
        check("wr_post_ResultW", ResultW, 32'hA5A5_0F0F);
        check("wr_post_RdW", RdW, 5'd14);
        dmem_bus.dmem_ack = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        // Load with no acknowledge: abort after TMO stalled cycles.
        drive(mk(1, 2'd1, 0, 0, 5'd20, 32'hC0, 0, 0, 0, 0, 0, 0, 0, 0));
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!StallM) break;
            cnt++;
            @(negedge clk);
        end
        check("tmo_stall_cycles", cnt, TMO);
        check("tmo_abort_req", dmem_bus.dmem_req, 1'b0);
        check("tmo_abort_StallM", StallM, 1'b0);
        @(negedge clk);
        check("tmo_mem_err", mem_err, 1'b1);
        check("tmo_RegWriteW", RegWriteW, 1'b0);
        apply(model(mk(1, 2'd0, 0, 0, 5'd21, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0)));
        check("tmo_mem_err_sticky", mem_err, 1'b1);
        #2 rst = 1'b0;
        #1 check("tmo_mem_err_rst", mem_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
`else
        cnt = 0;
        check("mem_err_tied", mem_err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, maximum WAIT cycles before abort (used only with DMEM_TIMEOUT_EN).
REQ-003 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have M-stage inputs: RegWriteM  in  1; ResultSrcM  in  2; MemWriteM  in  1; LUIInstrM  in  1; RdM  in  5; ALUResultM, WriteDataM, ExtImmM, PCPlus4M  in  XLEN each.
REQ-005 SHALL have memory ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  XLEN; dmem_wdata  out  XLEN; dmem_rdata  in  XLEN; dmem_ack  in  1.
REQ-006 SHALL have hazard output StallM  out  1, which freezes F/D/E and the EX/MEM register.
REQ-007 SHALL have W-stage outputs: RegWriteW  out  1; RdW  out  5; ResultW  out  XLEN; mem_err  out  1, sticky abort flag.

Function
REQ-008 memop = MemWriteM | (ResultSrcM==2'b01); a load is ResultSrcM==2'b01 with MemWriteM=0.
REQ-009 FSM states: IDLE, WAIT, ABORT; WAIT and ABORT are reachable only for a memop.
REQ-010 dmem_req = memop in IDLE or WAIT; dmem_we = MemWriteM; dmem_addr = ALUResultM; dmem_wdata = WriteDataM; all held stable until ack or abort.
REQ-011 IDLE, memop, dmem_ack=1: zero-wait access; StallM=0; W registers load at this edge.
REQ-012 IDLE, memop, dmem_ack=0: StallM=1; next state WAIT; W loads a bubble (RegWriteW=0).
REQ-013 WAIT, dmem_ack=0: StallM=1; remain in WAIT; bubble to W.
REQ-014 WAIT, dmem_ack=1: StallM=0; W registers load; next state IDLE.
REQ-015 Non-memop: StallM=0; dmem_req=0; W registers load every edge (1-cycle latency).
REQ-016 Result select: LUIInstrM=1 selects ExtImmM; otherwise ResultSrcM 00 ALUResultM, 01 dmem_rdata sampled at the ack edge, 10 PCPlus4M, 11 ExtImmM.
REQ-017 W load: RegWriteW<=RegWriteM, RdW<=RdM, ResultW<=selected result; a store writes RegWriteW=0 regardless of RegWriteM.
REQ-018 dmem_ack outside an active dmem_req SHALL be ignored.

Reset
REQ-019 rst=0 SHALL force IDLE, RegWriteW=0, RdW=0, ResultW=0, mem_err=0, and the wait counter to 0, immediately and independent of clk.
REQ-020 Reset during WAIT SHALL drop dmem_req and StallM in the same cycle; the in-flight access is discarded.

Configuration
REQ-021 Macro DMEM_TIMEOUT_EN defined: the wait counter increments each WAIT cycle; on reaching TIMEOUT_CYCLES without ack, the next state is ABORT.
REQ-022 ABORT (one cycle): dmem_req=0, StallM=0, bubble to W, mem_err<=1 and held until reset, next state IDLE; the instruction is dropped.
REQ-023 DMEM_TIMEOUT_EN undefined: no counter and no ABORT state; WAIT persists indefinitely; mem_err tied 0.

Structure
REQ-024 A shared package SHALL hold the ResultSrc encodings (RES_ALU=00, RES_MEM=01, RES_PC4=10, RES_IMM=11) and the FSM state enum.
REQ-025 W-stage registers SHALL use sub-module regPipe (clk, rst, clear, enable, d, q); the bubble is applied via clear.
REQ-026 FSM, counter and result mux SHALL be local to mem_wb_stage.

Verification
REQ-027 ALU op, ResultSrcM=00, ALUResultM=0x10, RdM=5 -> next edge RegWriteW=1, RdW=5, ResultW=0x10, StallM=0 throughout.
REQ-028 Load, ALUResultM=0x40, dmem_ack after 3 cycles, rdata=0xDEADBEEF -> StallM=1 for 3 cycles, dmem_addr=0x40 held, then ResultW=0xDEADBEEF.
REQ-029 Store, ack in same cycle -> dmem_we=1, dmem_wdata=WriteDataM, StallM never asserted, RegWriteW=0.
REQ-030 LUIInstrM=1, ExtImmM=0x12345000 -> ResultW=0x12345000 regardless of ResultSrcM.
REQ-031 DMEM_TIMEOUT_EN, load with no ack -> StallM high 15 cycles, ABORT, mem_err=1 and sticky, RegWriteW=0.
REQ-032 rst pulsed low in WAIT -> dmem_req=0, StallM=0, outputs zero asynchronously; FSM in IDLE after release.
